frame_sync: RTL
===============

# frame_sync

Receive-side frame synchroniser between the clock/data recovery stage and the output FIFO. It consumes the recovered bit stream (data bit plus valid flag) and hunts for the 802.15.4 start-of-frame delimiter. It then captures the PHY header length and forwards exactly that many payload octets, bit by bit, as FIFO write strobes. Incomplete frames, zero-length frames and FIFO overruns are flagged, and the block always recovers to hunting.

## Interface
Parameters:
- SFD, 8'hA7, start-of-frame delimiter, transmitted LSB first
- GAP_TIMEOUT, 64, clock cycles without inFlag while in a frame before the frame is aborted; legal range 2..255

Ports:
- Clock and reset: one clock `inClock`; reset `inReset` is synchronous and active-high.
- inClock, in, 1, system clock
- inReset, in, 1, synchronous active-high reset
- inData, in, 1, recovered bit from CDR; valid only when inFlag=1
- inFlag, in, 1, single-cycle bit-valid strobe from CDR
- inFull, in, 1, output FIFO full
- outWriteEnable, out, 1, FIFO write strobe (one payload bit)
- outData, out, 1, payload bit accompanying outWriteEnable
- outFrameStart, out, 1, one-cycle pulse when a valid PHR is accepted
- outFrameEnd, out, 1, one-cycle pulse coincident with the last payload bit
- outLength, out, 7, PHR length in octets; held until the next PHR is accepted
- outBusy, out, 1, high in HEADER or PAYLOAD
- outLengthError, out, 1, one-cycle pulse when the PHR length is 0
- outAbort, out, 1, one-cycle pulse on gap timeout
- outOverflow, out, 1, one-cycle pulse when a payload bit is dropped because inFull=1

## Operation
- Bit order is LSB first throughout. On each inFlag the shift register updates as sr <= {inData, sr[7:1]}.
- **HUNT**
  - Shift every flagged bit into sr.
  - When the updated sr == SFD: clear the bit counter and go to HEADER.
  - Matching is sliding, so overlapping patterns are found.
- **HEADER**
  - Collect 8 flagged bits as the PHR, with bit 0 first.
  - Length = PHR[6:0]. PHR[7] is reserved and ignored.
  - Length == 0: pulse outLengthError and return to HUNT.
  - Length > 0: latch outLength, pulse outFrameStart, load the payload counter with length*8 (10 bits, max 1016), and go to PAYLOAD.
- **PAYLOAD**
  - Each flagged bit: if inFull=0, assert outWriteEnable with outData=inData. If inFull=1, drop the bit and pulse outOverflow.
  - The counter decrements in both cases.
  - On the last bit: pulse outFrameEnd (together with outWriteEnable if that bit is written), clear sr, and go to HUNT.
- **Gap watchdog**
  - In HEADER or PAYLOAD, count cycles since the last inFlag. inFlag reloads the count.
  - Reaching GAP_TIMEOUT: pulse outAbort, clear sr, and go to HUNT. Any partial frame already written stays in the FIFO.
  - In HUNT the watchdog is held cleared.
- inFlag arriving in the same cycle as the timeout: the flag wins and the bit is processed.

## Timing
- All outputs are registered. Each response appears one cycle after the inFlag cycle that caused it.
- Reset values: all pulses, outWriteEnable, outData and outBusy = 0; outLength = 0; state = HUNT; sr = 0; counters = 0.
- Reset asserted mid-frame: the next cycle is HUNT with all outputs 0 and no outFrameEnd.
- Back-to-back frames: the SFD of frame N+1 may begin on the bit directly after frame N's last bit.
- outBusy rises the cycle after the SFD match and falls the cycle after the last bit, length error or abort.
- The minimum inFlag spacing is 1 cycle, so a flag every cycle is legal.

## Structure
- `frame_sync_pkg`: the state enum {HUNT, HEADER, PAYLOAD}, SFD_DEFAULT = 8'hA7, PHR_BITS = 8, LEN_W = 7, CNT_W = 10.
- One sub-module, `bit_gap_timer`: a loadable down-counter with a clear input and a timeout pulse output, parameterised by GAP_TIMEOUT.
- The FSM, shift register and payload counter live in `frame_sync`.

## Test plan
- Frame: bits of A7, then PHR 02, then payload 3C, 81, all LSB first, with a flag every 3 cycles.
  - Expect one outFrameStart, outLength = 2, and 16 writes carrying 0,0,1,1,1,1,0,0,1,0,0,0,0,0,0,1.
  - outFrameEnd coincides with the 16th write.
- 20 random bits containing A6, followed by A7 straddling earlier bits, then PHR 01, payload FF.
  - Expect exactly one frame and 8 writes of 1.
- A7 followed by PHR 80 (length 0, reserved bit set).
  - Expect outLengthError, no writes, and return to HUNT.
- A7, PHR 04, 10 payload bits, then no flags for 64 cycles.
  - Expect outAbort, outBusy = 0, and no outFrameEnd. A following valid frame is received normally.
- PHR 01 with inFull = 1 during bits 3–4.
  - Expect 2 outOverflow pulses, 6 writes, and outFrameEnd still asserted on the 8th bit.
- inReset asserted mid-payload.
  - Next cycle: all outputs 0, HUNT state. A new A7 + PHR 01 frame is then received correctly.

Source files
------------

// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the receive-side frame synchroniser.
// Bits arrive LSB first; the helpers below keep that ordering in one place.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } syncState_e;

  localparam logic [7:0] SFD_DEFAULT = 8'hA7;
  localparam int PHR_BITS = 8;
  localparam int LEN_W    = 7;
  localparam int CNT_W    = 10;

  // Payload bit count for a length in octets (max 127 * 8 = 1016).
  function automatic logic [CNT_W-1:0] payloadBits(input logic [LEN_W-1:0] lenOctets);
    return {lenOctets, 3'b000};
  endfunction

endpackage

// File: rtl/frame_sync_bit_gap_timer.sv
// Gap watchdog: reloads on every bit strobe and reports a timeout once
// GAP_TIMEOUT consecutive cycles have passed without one.
module bit_gap_timer
#(
  parameter int GAP_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic timeout
);

  localparam logic [7:0] RELOAD = 8'(GAP_TIMEOUT - 1);

  logic [7:0] remain_r;
  logic [7:0] remainNext_s;

  // Count selection: clear and load both rearm, otherwise count down to zero.
  always_comb begin
    remainNext_s = remain_r;
    if (clear || load) begin
      remainNext_s = RELOAD;
    end else if (remain_r != 8'd0) begin
      remainNext_s = remain_r - 8'd1;
    end else begin
      remainNext_s = remain_r;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      remain_r <= 8'd0;
    end else begin
      remain_r <= remainNext_s;
    end
  end

  // A strobe in the expiring cycle wins, so load suppresses the timeout.
  assign timeout = !clear && !load && (remain_r == 8'd0);

endmodule

// File: rtl/frame_sync.sv
// Frame synchroniser: hunts for the SFD in the recovered bit stream, captures
// the PHR length and forwards that many payload octets as FIFO write strobes.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter logic [7:0] SFD         = SFD_DEFAULT,
  parameter int         GAP_TIMEOUT = 64
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             inData,
  input  logic             inFlag,
  input  logic             inFull,
  output logic             outWriteEnable,
  output logic             outData,
  output logic             outFrameStart,
  output logic             outFrameEnd,
  output logic [LEN_W-1:0] outLength,
  output logic             outBusy,
  output logic             outLengthError,
  output logic             outAbort,
  output logic             outOverflow
);

  syncState_e state_r;
  syncState_e stateNext_s;

  // sr[0] falls out on every update, so only the upper seven bits are stored.
  logic [PHR_BITS-2:0] srHist_r;
  logic [PHR_BITS-1:0] srUpdated_s;
  logic [LEN_W-1:0]    phr_r;
  logic [2:0]          hdrCnt_r;
  logic [CNT_W-1:0]    payCnt_r;

  logic sfdHit_s;
  logic hdrLast_s;
  logic payLast_s;
  logic inFrame_s;
  logic timeout_s;

  logic             weNext_s;
  logic             dataNext_s;
  logic             startNext_s;
  logic             endNext_s;
  logic             lenErrNext_s;
  logic             abortNext_s;
  logic             ovfNext_s;
  logic             busyNext_s;
  logic [LEN_W-1:0] lengthNext_s;

  assign srUpdated_s = {inData, srHist_r};
  assign sfdHit_s    = (srUpdated_s == SFD);
  assign hdrLast_s   = (hdrCnt_r == 3'd7);
  assign payLast_s   = (payCnt_r == CNT_W'(1));
  assign inFrame_s   = (state_r != HUNT);

  bit_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) gapTimer (
    .clock  (inClock),
    .reset  (inReset),
    .clear  (!inFrame_s),
    .load   (inFlag),
    .timeout(timeout_s)
  );

  // State register.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_r <= HUNT;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic; a bit strobe always takes priority over the watchdog.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      HUNT: begin
        if (inFlag && sfdHit_s) begin
          stateNext_s = HEADER;
        end else begin
          stateNext_s = HUNT;
        end
      end
      HEADER: begin
        if (inFlag && hdrLast_s) begin
          stateNext_s = (phr_r == 7'd0) ? HUNT : PAYLOAD;
        end else if (!inFlag && timeout_s) begin
          stateNext_s = HUNT;
        end else begin
          stateNext_s = HEADER;
        end
      end
      PAYLOAD: begin
        if (inFlag && payLast_s) begin
          stateNext_s = HUNT;
        end else if (!inFlag && timeout_s) begin
          stateNext_s = HUNT;
        end else begin
          stateNext_s = PAYLOAD;
        end
      end
      default: stateNext_s = HUNT;
    endcase
  end

  // Shift register, PHR capture and payload bit counter.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      srHist_r <= 7'd0;
      phr_r    <= 7'd0;
      hdrCnt_r <= 3'd0;
      payCnt_r <= 10'd0;
    end else begin
      case (state_r)
        HUNT: begin
          hdrCnt_r <= 3'd0;
          if (inFlag) begin
            srHist_r <= srUpdated_s[PHR_BITS-1:1];
          end
        end
        HEADER: begin
          if (inFlag) begin
            hdrCnt_r <= hdrCnt_r + 3'd1;
            // The eighth PHR bit is the reserved bit and is never stored.
            if (hdrLast_s) begin
              payCnt_r <= payloadBits(phr_r);
            end else begin
              phr_r <= {inData, phr_r[LEN_W-1:1]};
            end
          end else if (timeout_s) begin
            srHist_r <= 7'd0;
          end
        end
        PAYLOAD: begin
          if (inFlag) begin
            payCnt_r <= payCnt_r - CNT_W'(1);
            if (payLast_s) begin
              srHist_r <= 7'd0;
            end
          end else if (timeout_s) begin
            srHist_r <= 7'd0;
            payCnt_r <= 10'd0;
          end
        end
        default: begin
          srHist_r <= 7'd0;
        end
      endcase
    end
  end

  // Output decode for the cycle after the current edge.
  always_comb begin
    weNext_s     = 1'b0;
    dataNext_s   = 1'b0;
    startNext_s  = 1'b0;
    endNext_s    = 1'b0;
    lenErrNext_s = 1'b0;
    abortNext_s  = 1'b0;
    ovfNext_s    = 1'b0;
    lengthNext_s = outLength;
    busyNext_s   = (stateNext_s != HUNT);
    case (state_r)
      HUNT: begin
        lengthNext_s = outLength;
      end
      HEADER: begin
        if (inFlag && hdrLast_s) begin
          if (phr_r == 7'd0) begin
            lenErrNext_s = 1'b1;
          end else begin
            startNext_s  = 1'b1;
            lengthNext_s = phr_r;
          end
        end else if (!inFlag && timeout_s) begin
          abortNext_s = 1'b1;
        end else begin
          abortNext_s = 1'b0;
        end
      end
      PAYLOAD: begin
        if (inFlag) begin
          if (inFull) begin
            ovfNext_s = 1'b1;
          end else begin
            weNext_s   = 1'b1;
            dataNext_s = inData;
          end
          endNext_s = payLast_s;
        end else if (timeout_s) begin
          abortNext_s = 1'b1;
        end else begin
          abortNext_s = 1'b0;
        end
      end
      default: begin
        lengthNext_s = outLength;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      outWriteEnable <= 1'b0;
      outData        <= 1'b0;
      outFrameStart  <= 1'b0;
      outFrameEnd    <= 1'b0;
      outLength      <= 7'd0;
      outBusy        <= 1'b0;
      outLengthError <= 1'b0;
      outAbort       <= 1'b0;
      outOverflow    <= 1'b0;
    end else begin
      outWriteEnable <= weNext_s;
      outData        <= dataNext_s;
      outFrameStart  <= startNext_s;
      outFrameEnd    <= endNext_s;
      outLength      <= lengthNext_s;
      outBusy        <= busyNext_s;
      outLengthError <= lenErrNext_s;
      outAbort       <= abortNext_s;
      outOverflow    <= ovfNext_s;
    end
  end

endmodule
